// File: rtl/sort_pkg.sv
// Shared constants for the bubble-sort display engine: array geometry and the
// two-bit state encoding that the top-level LED decode relies on.
package sort_pkg;

  localparam int SORT_N = 32;
  localparam int SORT_W = 8;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_COMPARE = 2'b01;
  localparam logic [1:0] S_SWAP    = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_COMPARE = S_COMPARE,
    ST_SWAP    = S_SWAP,
    ST_DONE    = S_DONE
  } sort_state_e;

endpackage

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort over an N x W register array, one compare or swap per
// step pulse so the renderer downstream can show every intermediate array.
module bubble_sort_engine
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int W = SORT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step_en,
  input  logic                 load_en,
  input  logic [$clog2(N)-1:0] load_idx,
  input  logic [W-1:0]         load_data,
  output logic [N*W-1:0]       vals,
  output logic [1:0]           state,
  output logic [$clog2(N)-1:0] cmp_idx,
  output logic [$clog2(N)-1:0] pass_cnt,
  output logic [9:0]           swap_cnt,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  logic [W-1:0]  mem_reg [N];
  sort_state_e   state_reg;
  logic [IW-1:0] cmp_idx_reg;
  logic [IW-1:0] pass_cnt_reg;
  logic [IW-1:0] limit_reg;
  logic [9:0]    swap_cnt_reg;
  logic          swapped_reg;
  logic          busy_reg;

  logic [IW-1:0] nxt_idx;
  logic [IW:0]   idx_plus1;
  logic [W-1:0]  lo_val;
  logic [W-1:0]  hi_val;
  logic          at_pass_end;
  logic          last_limit;
  logic          swapped_after;

  assign nxt_idx     = cmp_idx_reg + IW'(1);
  assign idx_plus1   = {1'b0, cmp_idx_reg} + (IW+1)'(1);
  assign lo_val      = mem_reg[cmp_idx_reg];
  assign hi_val      = mem_reg[nxt_idx];
  assign at_pass_end = (idx_plus1 >= {1'b0, limit_reg});
  assign last_limit  = (limit_reg == IW'(1));
  // A swap on the final pair of a pass must count as "something moved".
  assign swapped_after = swapped_reg | (state_reg == ST_SWAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        mem_reg[k] <= W'(255 - 8 * k);
      end
      state_reg    <= ST_IDLE;
      cmp_idx_reg  <= '0;
      pass_cnt_reg <= '0;
      swap_cnt_reg <= '0;
      limit_reg    <= IW'(N - 1);
      swapped_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (load_en && (32'(load_idx) < N)) begin
            mem_reg[load_idx] <= load_data;
          end
          if (start) begin
            state_reg    <= ST_COMPARE;
            busy_reg     <= 1'b1;
            cmp_idx_reg  <= '0;
            pass_cnt_reg <= '0;
            swap_cnt_reg <= '0;
            limit_reg    <= IW'(N - 1);
            swapped_reg  <= 1'b0;
          end
        end

        ST_COMPARE, ST_SWAP: begin
          if (step_en) begin
            if (state_reg == ST_COMPARE && lo_val > hi_val) begin
              state_reg <= ST_SWAP;
            end else begin
              if (state_reg == ST_SWAP) begin
                mem_reg[cmp_idx_reg] <= hi_val;
                mem_reg[nxt_idx]     <= lo_val;
                swapped_reg          <= 1'b1;
                swap_cnt_reg         <= swap_cnt_reg + 10'd1;
              end
              // Advance: next pair, next pass, or finish.
              if (!at_pass_end) begin
                cmp_idx_reg <= nxt_idx;
                state_reg   <= ST_COMPARE;
              end else if (!swapped_after || last_limit) begin
                state_reg <= ST_DONE;
                busy_reg  <= 1'b0;
              end else begin
                limit_reg    <= limit_reg - IW'(1);
                cmp_idx_reg  <= '0;
                swapped_reg  <= 1'b0;
                pass_cnt_reg <= pass_cnt_reg + IW'(1);
                state_reg    <= ST_COMPARE;
              end
            end
          end
        end

        ST_DONE: begin
          if (step_en && !start) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign vals[gi*W +: W] = mem_reg[gi];
  end

  assign state    = state_reg;
  assign cmp_idx  = cmp_idx_reg;
  assign pass_cnt = pass_cnt_reg;
  assign swap_cnt = swap_cnt_reg;
  assign busy     = busy_reg;

endmodule
